ddr3_command_responder: RTL

DDR3_COMMAND_RESPONDER -- requirements
Module: ddr3_command_responder

---
 rtl/ddr3_command_responder.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/ddr3_command_responder.sv
// Behavioural DDR3 command responder: decodes bus commands, tracks bank state and runs fixed BL8 data bursts.
// Optional protocol checking is built in when RESPONDER_PROTOCOL_CHECK_EN is defined.
module ddr3_command_responder #(
  parameter int ADDRESS_BITWIDTH      = 15,
  parameter int BANK_ADDRESS_BITWIDTH = 3,
  parameter int DQ_BITWIDTH           = 16,
  parameter int CAS_LATENCY           = 5,
  parameter int CAS_WRITE_LATENCY     = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ck_en,
  input  logic                             cs_n,
  input  logic                             ras_n,
  input  logic                             cas_n,
  input  logic                             we_n,
  input  logic [ADDRESS_BITWIDTH-1:0]      address,
  input  logic [BANK_ADDRESS_BITWIDTH-1:0] bank_address,
  input  logic [DQ_BITWIDTH-1:0]           dq_in,
  input  logic [DQ_BITWIDTH/8-1:0]         dm_in,
  output logic [DQ_BITWIDTH-1:0]           dq_out,
  output logic                             dq_oe,
  output logic [15:0]                      refresh_count,
  output logic                             protocol_error,
  output logic                             overlap_error
);

  localparam int NUM_BANKS = 1 << BANK_ADDRESS_BITWIDTH;
  localparam int DEPTH     = NUM_BANKS * 8;
  localparam int IDX_W     = BANK_ADDRESS_BITWIDTH + 3;
  localparam int NUM_BYTES = DQ_BITWIDTH / 8;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_WR     = 3'd1,
    WRITE_BURST = 3'd2,
    WAIT_RD     = 3'd3,
    READ_BURST  = 3'd4
  } state_t;

  state_t                           state_q, state_d;
  logic [7:0]                       lat_q, lat_d;
  logic [2:0]                       beat_q, beat_d;
  logic [BANK_ADDRESS_BITWIDTH-1:0] bank_q, bank_d;
  logic [2:0]                       col_q, col_d;
  logic [NUM_BANKS-1:0]             open_q, open_d;
  logic [ADDRESS_BITWIDTH-1:0]      row_q [NUM_BANKS];
  logic [ADDRESS_BITWIDTH-1:0]      row_d [NUM_BANKS];
  logic [DQ_BITWIDTH-1:0]           mem_q [DEPTH];
  logic [DQ_BITWIDTH-1:0]           mem_d [DEPTH];
  logic [DQ_BITWIDTH-1:0]           dq_out_q, dq_out_d;
  logic                             dq_oe_q, dq_oe_d;
  logic [15:0]                      ref_q, ref_d;
  logic                             ovl_q, ovl_d;

  logic       cmd_valid;
  logic [2:0] cmd;
  logic       is_act, is_rd, is_wr, is_pre, is_ref;
  logic [2:0] cur_col;
  logic [IDX_W-1:0] cur_idx;
  logic       wr_en;

  // MRS, ZQCL and NOP decode to nothing: they have no state effect.
  assign cmd_valid = ck_en & ~cs_n;
  assign cmd       = {ras_n, cas_n, we_n};
  assign is_act    = cmd_valid && (cmd == 3'b011);
  assign is_rd     = cmd_valid && (cmd == 3'b101);
  assign is_wr     = cmd_valid && (cmd == 3'b100);
  assign is_pre    = cmd_valid && (cmd == 3'b010);
  assign is_ref    = cmd_valid && (cmd == 3'b001);

  // Beat k of a burst wraps within the 8-word block selected by the bank.
  assign cur_col = col_q + beat_q;
  assign cur_idx = {bank_q, cur_col};

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    beat_d   = beat_q;
    bank_d   = bank_q;
    col_d    = col_q;
    open_d   = open_q;
    row_d    = row_q;
    ref_d    = ref_q;
    ovl_d    = ovl_q;
    dq_out_d = '0;
    dq_oe_d  = 1'b0;
    wr_en    = 1'b0;

    if (is_act) begin
      open_d[bank_address] = 1'b1;
      row_d[bank_address]  = address;
    end
    if (is_pre) begin
      if (address[10]) open_d = '0;
      else             open_d[bank_address] = 1'b0;
    end
    if (is_ref && (ref_q != 16'hFFFF)) ref_d = ref_q + 16'd1;
    if ((is_rd || is_wr) && (state_q != IDLE)) ovl_d = 1'b1;

    case (state_q)
      IDLE: begin
        beat_d = 3'd0;
        if (is_wr) begin
          state_d = WAIT_WR;
          lat_d   = 8'(CAS_WRITE_LATENCY - 1);
          bank_d  = bank_address;
          col_d   = address[2:0];
        end else if (is_rd) begin
          state_d = WAIT_RD;
          lat_d   = 8'(CAS_LATENCY - 1);
          bank_d  = bank_address;
          col_d   = address[2:0];
        end
      end
      WAIT_WR: begin
        if (lat_q == 8'd0) begin
          wr_en   = 1'b1;
          beat_d  = 3'd1;
          state_d = WRITE_BURST;
        end else begin
          lat_d = lat_q - 8'd1;
        end
      end
      WRITE_BURST: begin
        wr_en  = 1'b1;
        beat_d = beat_q + 3'd1;
        if (beat_q == 3'd7) state_d = IDLE;
      end
      WAIT_RD: begin
        if (lat_q == 8'd0) begin
          dq_out_d = mem_q[cur_idx];
          dq_oe_d  = 1'b1;
          beat_d   = 3'd1;
          state_d  = READ_BURST;
        end else begin
          lat_d = lat_q - 8'd1;
        end
      end
      READ_BURST: begin
        dq_out_d = mem_q[cur_idx];
        dq_oe_d  = 1'b1;
        beat_d   = beat_q + 3'd1;
        if (beat_q == 3'd7) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (!dm_in[b]) mem_d[cur_idx][b*8 +: 8] = dq_in[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      beat_q   <= '0;
      bank_q   <= '0;
      col_q    <= '0;
      open_q   <= '0;
      row_q    <= '{default: '0};
      mem_q    <= '{default: '0};
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
      ref_q    <= '0;
      ovl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      beat_q   <= beat_d;
      bank_q   <= bank_d;
      col_q    <= col_d;
      open_q   <= open_d;
      row_q    <= row_d;
      mem_q    <= mem_d;
      dq_out_q <= dq_out_d;
      dq_oe_q  <= dq_oe_d;
      ref_q    <= ref_d;
      ovl_q    <= ovl_d;
    end
  end

`ifdef RESPONDER_PROTOCOL_CHECK_EN
  logic prot_q, prot_d;

  // Checks use bank state from before this edge's ACT/PRE update.
  always_comb begin
    prot_d = prot_q;
    if ((is_rd || is_wr) && !open_q[bank_address]) prot_d = 1'b1;
    if (is_act && open_q[bank_address])            prot_d = 1'b1;
    if (is_ref && (|open_q))                       prot_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) prot_q <= 1'b0;
    else       prot_q <= prot_d;
  end

  assign protocol_error = prot_q;
`else
  assign protocol_error = 1'b0;
`endif

  assign dq_out        = dq_out_q;
  assign dq_oe         = dq_oe_q;
  assign refresh_count = ref_q;
  assign overlap_error = ovl_q;

endmodule
